// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory between fetch and execute.
// Pipelined issue of at most one grant per cycle; response data is returned one cycle after the grant.
//
// state   | meaning
// --------+--------------------------------------
// IDLE    | no response pending
// IF_RESP | fetch read issued last cycle
// DM_RESP | data access issued last cycle
module mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_gnt,
   output logic                    if_valid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   output logic                    if_stall,
   input  logic                    dm_req,
   input  logic                    dm_we,
   input  logic [ADDR_WIDTH-1:0]   dm_addr,
   input  logic [DATA_WIDTH-1:0]   dm_wdata,
   input  logic [DATA_WIDTH/8-1:0] dm_be,
   output logic                    dm_gnt,
   output logic                    dm_valid,
   output logic [DATA_WIDTH-1:0]   dm_rdata,
   output logic                    dm_stall,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_RESP = 2'd1,
      DM_RESP = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   last_gnt, last_gnt_nxt;
   logic   store_q, store_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_gnt <= 1'b0;
         store_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         last_gnt <= last_gnt_nxt;
         store_q  <= store_nxt;
      end
   end

   always_comb begin
      if_gnt       = 1'b0;
      dm_gnt       = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_be       = '0;
      state_nxt    = IDLE;
      last_gnt_nxt = last_gnt;
      store_nxt    = 1'b0;

      // On a conflict the port that did not win last time gets the slot.
      if (!rst) begin
         if (if_req && dm_req) begin
            if (last_gnt) if_gnt = 1'b1;
            else          dm_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end else if (dm_req) begin
            dm_gnt = 1'b1;
         end
      end

      if (if_gnt) begin
         mem_en       = 1'b1;
         mem_addr     = if_addr;
         mem_be       = '1;
         state_nxt    = IF_RESP;
         last_gnt_nxt = 1'b0;
      end else if (dm_gnt) begin
         mem_en       = 1'b1;
         mem_we       = dm_we;
         mem_addr     = dm_addr;
         mem_wdata    = dm_wdata;
         mem_be       = dm_be;
         state_nxt    = DM_RESP;
         last_gnt_nxt = 1'b1;
         store_nxt    = dm_we;
      end
   end

   assign if_stall = if_req & ~if_gnt;
   assign dm_stall = dm_req & ~dm_gnt;

   // A response whose cycle coincides with reset is dropped.
   assign if_valid = (state == IF_RESP) && !rst;
   assign dm_valid = (state == DM_RESP) && !rst;
   assign if_rdata = if_valid ? mem_rdata : '0;
   assign dm_rdata = (dm_valid && !store_q) ? mem_rdata : '0;

endmodule
